multicycle_sequencer: RTL
=========================

# multicycle_sequencer

Multicycle control FSM that steps the MIPS datapath through fetch, decode, execute, memory and write-back. It consumes the decoder's `opfunc_t` classification plus load/store/halt flags and the ALU zero flag. It drives the instruction/data memory request lines, the IR/PC/register-file write strobes and the PC source select. It sits between the combinational control unit and the shared memory/datapath, and replaces the single-cycle enable path.

## Interface
- No parameters. `opfunc` is typed `control_unit_types_pkg::opfunc_t`.
- CLK  in  1  rising-edge clock
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction memory ready; data valid this cycle
- dhit  in  1  data memory ready; access complete this cycle
- opfunc  in  3  decoded class: OJR, OBEQ, OBNE, OJ, OJAL, OTHERR, OTHERI, OTHERJ
- is_load, is_store, is_halt  in  1 each  decoder flags for the current IR
- zero  in  1  ALU zero flag
- iREN  out  1  instruction read request
- dREN, dWEN  out  1 each  data read and write requests
- ir_wen, pc_wen, reg_wen  out  1 each  single-cycle write strobes
- pc_sel  out  2  PC source: 0 = PC+4, 1 = branch target, 2 = jump target, 3 = register (JR)
- halt  out  1  sticky halt indicator
- state_o  out  3  current state encoding, for debug

## Operation
- States and encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALT = 5. Encodings 6 and 7 go to FETCH on the next edge with no strobes.
- Latching at DECODE exit: `opfunc`, `is_load`, `is_store` are captured into internal registers. EXEC, MEM and WB use only the latched copies.
- FETCH:
  - iREN = 1.
  - On ihit: ir_wen = 1, go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - is_halt → HALT.
  - Otherwise → EXEC.
- EXEC:
  - OBEQ: pc_wen = 1; pc_sel = zero ? 1 : 0; → FETCH.
  - OBNE: same, using !zero.
  - OJ: pc_wen = 1, pc_sel = 2, → FETCH.
  - OJR: pc_wen = 1, pc_sel = 3, → FETCH.
  - OJAL: → WB.
  - OTHERR/OTHERI with load or store latched: → MEM.
  - OTHERR/OTHERI otherwise: → WB.
  - OTHERJ: treated as a NOP; pc_wen = 1, pc_sel = 0, → FETCH.
- MEM:
  - dREN = latched load; dWEN = latched store && !latched load. If both flags are set, the load wins.
  - Stay in MEM until dhit.
  - On dhit with a load: → WB.
  - On dhit with a store: pc_wen = 1, pc_sel = 0, → FETCH.
- WB:
  - reg_wen = 1, pc_wen = 1.
  - pc_sel = 2 if OJAL latched, else 0.
  - → FETCH.
- HALT: halt = 1. All request lines and strobes are 0. The block stays in HALT until reset.
- Output decoding: iREN/dREN/dWEN are decoded from state only (Moore). Strobes and pc_sel are decoded from state plus inputs (Mealy). pc_sel = 0 whenever pc_wen = 0.
- Memory-ready inputs outside their state: ihit outside FETCH and dhit outside MEM are ignored.

## Timing
- Reset: while nRST = 0, state = FETCH and every output is forced to 0, including iREN and halt. Reset asserted mid-access aborts the access immediately. No strobe may be issued in the reset-release cycle unless ihit is high in FETCH.
- Zero-wait memory latencies (ihit/dhit high on first request cycle):
  - Branch/J/JR/NOP: 3 cycles.
  - R/I ALU: 4 cycles.
  - JAL: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each wait cycle on ihit or dhit adds exactly 1 cycle.
- pc_wen pulses exactly once per retired instruction. ir_wen pulses exactly once per fetch.
- Request lines hold steady, with no glitch to 0, for the entire wait in FETCH or MEM.

## Configuration
- Macro: `SEQ_PERF_COUNTERS_EN`.
- When defined, the block adds two outputs:
  - `cycle_cnt` [31:0]: increments every cycle while nRST = 1 and state ≠ HALT.
  - `instr_cnt` [31:0]: increments on every pc_wen pulse.
- Both counters reset to 0 and wrap from 0xFFFFFFFF to 0.
- When undefined, the ports and the counter logic are absent. FSM behaviour is identical in both builds.

## Test plan
- Reset, then ihit = 1 and an R-type (OTHERR, no load/store) → states 0, 1, 2, 4, 0. reg_wen and pc_wen both pulse in cycle 4 with pc_sel = 0. With the macro defined, instr_cnt = 1 and cycle_cnt = 4.
- Load with dhit delayed 3 cycles → dREN high for 4 consecutive cycles, then WB with reg_wen = 1. Total 8 cycles.
- BEQ with zero = 1 → pc_wen with pc_sel = 1 in EXEC. BNE with zero = 1 → pc_sel = 0. JR → pc_sel = 3. JAL → WB pulses reg_wen with pc_sel = 2.
- Store with is_load and is_store both set → dREN = 1, dWEN = 0, and a WB follows.
- Halt → halt = 1 two cycles after ir_wen. halt stays 1 and iREN stays 0 for 100 cycles with ihit toggling. The counters freeze.
- nRST pulsed low mid-MEM wait → all outputs 0 immediately. After release: state_o = 0, iREN = 1, and no dWEN issued. Counters are 0.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM stepping the MIPS datapath through fetch/decode/exec/mem/wb.
// Latency: 3 (branch/jump/nop), 4 (ALU/JAL/store), 5 (load) cycles plus one per memory wait cycle.
// Backpressure: stalls in FETCH until ihit and in MEM until dhit; optional perf counters via SEQ_PERF_COUNTERS_EN.
package control_unit_types_pkg;
    typedef enum logic [2:0] {
        OJR    = 3'd0,
        OBEQ   = 3'd1,
        OBNE   = 3'd2,
        OJ     = 3'd3,
        OJAL   = 3'd4,
        OTHERR = 3'd5,
        OTHERI = 3'd6,
        OTHERJ = 3'd7
    } opfunc_t;
endpackage

module multicycle_sequencer
    import control_unit_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  opfunc_t     opfunc,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        is_halt,
    input  logic        zero,
    output logic        iREN,
    output logic        dREN,
    output logic        dWEN,
    output logic        ir_wen,
    output logic        pc_wen,
    output logic        reg_wen,
    output logic [1:0]  pc_sel,
    output logic        halt,
    output logic [2:0]  state_o
`ifdef SEQ_PERF_COUNTERS_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t  state;
    opfunc_t op_q;
    logic    ld_q;
    logic    st_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= FETCH;
            op_q  <= OJR;
            ld_q  <= 1'b0;
            st_q  <= 1'b0;
        end else begin
            case (state)
                FETCH:  if (ihit) state <= DECODE;
                DECODE: begin
                    op_q  <= opfunc;
                    ld_q  <= is_load;
                    st_q  <= is_store;
                    state <= is_halt ? HALT : EXEC;
                end
                EXEC: begin
                    case (op_q)
                        OJAL:           state <= WB;
                        OTHERR, OTHERI: state <= (ld_q || st_q) ? MEM : WB;
                        default:        state <= FETCH;
                    endcase
                end
                MEM:    if (dhit) state <= ld_q ? WB : FETCH;
                WB:     state <= FETCH;
                HALT:   state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    // Outputs are gated by nRST so every line drops the moment reset asserts.
    always_comb begin
        iREN    = 1'b0;
        dREN    = 1'b0;
        dWEN    = 1'b0;
        ir_wen  = 1'b0;
        pc_wen  = 1'b0;
        reg_wen = 1'b0;
        pc_sel  = 2'd0;
        halt    = 1'b0;
        if (nRST) begin
            case (state)
                FETCH: begin
                    iREN   = 1'b1;
                    ir_wen = ihit;
                end
                EXEC: begin
                    case (op_q)
                        OBEQ: begin
                            pc_wen = 1'b1;
                            pc_sel = zero ? 2'd1 : 2'd0;
                        end
                        OBNE: begin
                            pc_wen = 1'b1;
                            pc_sel = zero ? 2'd0 : 2'd1;
                        end
                        OJ: begin
                            pc_wen = 1'b1;
                            pc_sel = 2'd2;
                        end
                        OJR: begin
                            pc_wen = 1'b1;
                            pc_sel = 2'd3;
                        end
                        OTHERJ:  pc_wen = 1'b1;
                        default: pc_wen = 1'b0;
                    endcase
                end
                MEM: begin
                    dREN   = ld_q;
                    dWEN   = st_q && !ld_q;
                    pc_wen = dhit && !ld_q;
                end
                WB: begin
                    reg_wen = 1'b1;
                    pc_wen  = 1'b1;
                    pc_sel  = (op_q == OJAL) ? 2'd2 : 2'd0;
                end
                HALT:    halt = 1'b1;
                default: halt = 1'b0;
            endcase
        end
    end

    assign state_o = state;

`ifdef SEQ_PERF_COUNTERS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            if (state != HALT) cycle_cnt <= cycle_cnt + 32'd1;
            if (pc_wen)        instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule
